// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit: operation and state encodings,
// privilege levels and the fixed CSR address fields.
package csr_pkg;

    typedef enum logic [1:0] {
        OP_RSV = 2'b00,
        OP_RW  = 2'b01,
        OP_RS  = 2'b10,
        OP_RC  = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PROBE = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } csr_state_e;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int ADDR_RO_HI   = 11;
    localparam int ADDR_RO_LO   = 10;
    localparam int ADDR_PRIV_HI = 9;
    localparam int ADDR_PRIV_LO = 8;

    function automatic logic addr_is_ro(input logic [11:0] addr);
        return (addr[ADDR_RO_HI:ADDR_RO_LO] == 2'b11);
    endfunction

    function automatic logic priv_denied(input logic [11:0] addr, input logic [1:0] priv);
        return (addr[ADDR_PRIV_HI:ADDR_PRIV_LO] > priv);
    endfunction

endpackage

// File: rtl/csr_mask_gen.sv
// Translates a CSR operation and its operand into the set/clear masks
// driven on the CSR bus during the write cycle.
module csr_mask_gen
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  csr_op_e          op_i,
    input  logic [XLEN-1:0]  operand_i,
    output logic [XLEN-1:0]  set_o,
    output logic [XLEN-1:0]  clear_o
);

    // Mask selection per operation
    always_comb begin
        set_o   = {XLEN{1'b0}};
        clear_o = {XLEN{1'b0}};
        case (op_i)
            OP_RW: begin
                set_o   = operand_i;
                clear_o = ~operand_i;
            end
            OP_RS: begin
                set_o   = operand_i;
                clear_o = {XLEN{1'b0}};
            end
            OP_RC: begin
                set_o   = {XLEN{1'b0}};
                clear_o = operand_i;
            end
            default: begin
                set_o   = {XLEN{1'b0}};
                clear_o = {XLEN{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// CSR bus initiator: accepts one CSR instruction, probes the target CSR,
// checks legality, issues at most one set/clear write and returns the old value.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic             req_imm_i,
    input  logic [11:0]      req_addr_i,
    input  logic [4:0]       req_rs1_idx_i,
    input  logic [XLEN-1:0]  req_rs1_data_i,
    input  logic [1:0]       priv_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  resp_rdata_o,
    output logic             resp_illegal_o,
    output logic             csr_en_o,
    output logic [11:0]      csr_addr_o,
    output logic [XLEN-1:0]  csr_set_o,
    output logic [XLEN-1:0]  csr_clear_o,
    input  logic [XLEN-1:0]  csr_rdata_i,
    input  logic             csr_ack_i
);

    localparam int               CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    csr_state_e        state_q, state_d;
    csr_op_e           op_q, op_d;
    logic [11:0]       addr_q, addr_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic              wreq_q, wreq_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   mask_set_s, mask_clear_s;

    csr_mask_gen #(.XLEN(XLEN)) u_mask_gen (
        .op_i      (op_q),
        .operand_i (operand_q),
        .set_o     (mask_set_s),
        .clear_o   (mask_clear_s)
    );

    // State and transaction registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RSV;
            addr_q    <= 12'h000;
            operand_q <= {XLEN{1'b0}};
            wreq_q    <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            rdata_q   <= {XLEN{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            operand_q <= operand_d;
            wreq_q    <= wreq_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and captured-data logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        operand_d = operand_q;
        wreq_d    = wreq_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d      = csr_op_e'(req_op_i);
                    addr_d    = req_addr_i;
                    operand_d = req_imm_i ? {{(XLEN-5){1'b0}}, req_rs1_idx_i} : req_rs1_data_i;
                    wreq_d    = (req_op_i == OP_RW) || (req_rs1_idx_i != 5'd0);
                    cnt_d     = {CNT_W{1'b0}};
                    rdata_d   = {XLEN{1'b0}};
                    // Reserved op or insufficient privilege fails before touching the bus
                    if ((req_op_i == OP_RSV) || priv_denied(req_addr_i, priv_i)) begin
                        illegal_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        illegal_d = 1'b0;
                        state_d   = ST_PROBE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROBE: begin
                if (csr_ack_i) begin
                    if (wreq_q && addr_is_ro(addr_q)) begin
                        illegal_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        rdata_d = csr_rdata_i;
                        state_d = wreq_q ? ST_WRITE : ST_RESP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    illegal_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state
    always_comb begin
        req_ready_o    = 1'b0;
        resp_valid_o   = 1'b0;
        resp_rdata_o   = {XLEN{1'b0}};
        resp_illegal_o = 1'b0;
        csr_en_o       = 1'b0;
        csr_addr_o     = 12'h000;
        csr_set_o      = {XLEN{1'b0}};
        csr_clear_o    = {XLEN{1'b0}};
        case (state_q)
            ST_IDLE: begin
                req_ready_o = rst_i;
            end
            ST_PROBE: begin
                csr_en_o   = 1'b1;
                csr_addr_o = addr_q;
            end
            ST_WRITE: begin
                csr_en_o    = 1'b1;
                csr_addr_o  = addr_q;
                csr_set_o   = mask_set_s;
                csr_clear_o = mask_clear_s;
            end
            ST_RESP: begin
                resp_valid_o   = 1'b1;
                resp_rdata_o   = illegal_q ? {XLEN{1'b0}} : rdata_q;
                resp_illegal_o = illegal_q;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

endmodule
